// File: rtl/o_star_accum_stage_pkg.sv
// Shared definitions for the O* accumulation stage of the attention row
// pipeline: element format, vector type and the stage's state encoding.
package o_star_accum_stage_pkg;

   // Element format shared with expmul_stage: signed Q9.17.
   localparam int EXPMUL_VEC_I      = 9;
   localparam int EXPMUL_VEC_F      = 17;
   localparam int EXPMUL_VEC_W      = EXPMUL_VEC_I + EXPMUL_VEC_F;

   // Row geometry. The vector carries MAX_EMBEDDING_DIM value elements plus
   // one trailing element holding the running row sum l.
   localparam int MAX_EMBEDDING_DIM = 4;
   localparam int MAX_SEQ_LENGTH    = 4;

   typedef logic signed [EXPMUL_VEC_W-1:0] EXPMUL_VEC_QT;
   typedef EXPMUL_VEC_QT [MAX_EMBEDDING_DIM:0] STAR_VECTOR_T;

   // ACCUM: taking per-key pairs. DONE: finished row waiting for downstream.
   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } O_ACC_STATE_T;

endpackage

// File: rtl/o_star_accum_stage_if.sv
// Pair-in / row-out bus of the O* accumulation stage. The slave view is the
// stage itself; the master view is whatever drives pairs in and takes rows out.
interface o_star_accum_stage_if
   import o_star_accum_stage_pkg::*;
#(
   parameter int EMB_DIM = MAX_EMBEDDING_DIM,
   parameter int W       = EXPMUL_VEC_W
) ();

   localparam int VW = (EMB_DIM + 1) * W;

   // Upstream side (from expmul_stage).
   logic          vld_in;
   logic          rdy_out;
   logic [VW-1:0] o_scaled_in;
   logic [VW-1:0] v_scaled_in;
   logic [VW-1:0] o_fb_out;

   // Downstream side (to the normalise/divide stage).
   logic          vld_out;
   logic          rdy_in;
   logic [VW-1:0] o_star_out;

   modport master (
      output vld_in, o_scaled_in, v_scaled_in, rdy_in,
      input  rdy_out, o_fb_out, vld_out, o_star_out
   );

   modport slave (
      input  vld_in, o_scaled_in, v_scaled_in, rdy_in,
      output rdy_out, o_fb_out, vld_out, o_star_out
   );

endinterface

// File: rtl/o_star_accum_stage_q_sat_add.sv
// Signed two's-complement adder that clamps to the W-bit range instead of
// wrapping. One instance per vector lane.
module q_sat_add #(
   parameter int W = 26
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W-1:0] sum_o
);

   localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   // One guard bit makes the sum exact; overflow shows as the top two bits differing.
   logic signed [W:0] wide;
   assign wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};

   // Clamp toward the sign of the exact sum when it leaves the W-bit range.
   always_comb begin
      if (wide[W] != wide[W-1]) begin
         sum_o = wide[W] ? SAT_MIN : SAT_MAX;
      end else begin
         sum_o = wide[W-1:0];
      end
   end

endmodule

// File: rtl/o_star_accum_stage.sv
// O* accumulation stage: sums each (rescaled O*, scaled V) pair lane-wise with
// saturation, feeds the running row back upstream, and after SEQ_LEN keys holds
// the finished row until the normalise/divide stage takes it.
module o_star_accum_stage
   import o_star_accum_stage_pkg::*;
#(
   parameter  int EMB_DIM = MAX_EMBEDDING_DIM,
   parameter  int SEQ_LEN = MAX_SEQ_LENGTH,
   parameter  int VEC_I   = EXPMUL_VEC_I,
   parameter  int VEC_F   = EXPMUL_VEC_F,
   localparam int W       = VEC_I + VEC_F,
   localparam int CNT_W   = $clog2(SEQ_LEN + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   o_star_accum_stage_if.slave   bus,
   output logic [CNT_W-1:0]      key_count
);

   localparam int               LANES    = EMB_DIM + 1;
   localparam int               VW       = LANES * W;
   localparam logic [CNT_W-1:0] LAST_KEY = CNT_W'(SEQ_LEN - 1);

   O_ACC_STATE_T     state_q, state_d;
   logic [VW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vld_q, vld_d;
   logic [VW-1:0]    sum;
   logic             rdy;
   logic             accept;

   // Per-lane saturating add of the incoming pair; lanes never interact.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      q_sat_add #(.W(W)) u_add (
         .a_i   (bus.o_scaled_in[i*W +: W]),
         .b_i   (bus.v_scaled_in[i*W +: W]),
         .sum_o (sum[i*W +: W])
      );
   end

   // Next-state and ready: rdy depends on the registered state only, so no
   // combinational path exists from vld_in or rdy_in to rdy_out.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      vld_d   = vld_q;
      rdy     = (state_q == ACCUM);
      accept  = bus.vld_in && rdy;

      case (state_q)
         ACCUM: begin
            if (accept) begin
               // The first key of a row has no prior O*, so its rescaled input is ignored.
               acc_d = (cnt_q == '0) ? bus.v_scaled_in : sum;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_KEY) begin
                  state_d = DONE;
                  vld_d   = 1'b1;
               end
            end
         end
         DONE: begin
            if (vld_q && bus.rdy_in) begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               vld_d   = 1'b0;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // State register; synchronous reset discards any partial row.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
      end
   end

   assign bus.rdy_out    = rdy;
   assign bus.vld_out    = vld_q;
   assign bus.o_fb_out   = acc_q;
   assign bus.o_star_out = acc_q;
   assign key_count      = cnt_q;

endmodule
